mio_bus_resp: RTL and testbench
===============================

// Module: mio_bus_resp
// PURPOSE
//  Memory/IO responder on the multi-cycle CPU's MIO bus: accepts MemRead/MemWrite requests qualified by CPU_MIO,
//  decodes the address to block RAM, LED register, switch port or cycle counter, and answers with a one-cycle
//  MIO_ready pulse. Sits between the multi-cycle controller/datapath and the board memory and peripherals.
// PARAMETERS
//  RAM_AW   10  RAM word-address width (RAM = 2^RAM_AW 32-bit words at byte addr 0x0000_0000 upward)
//  RAM_LAT  1   RAM read latency in cycles (1..4); writes complete in 1 cycle regardless
//  CNT_W    32  cycle counter width, zero-extended to 32 on read
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  reset      in   1       asynchronous, active-low reset
//  CPU_MIO    in   1       CPU owns bus / request qualifier
//  MemRead    in   1       read request (held by CPU until MIO_ready seen)
//  MemWrite   in   1       write request (held by CPU until MIO_ready seen)
//  addr_bus   in   32      byte address, word aligned (addr_bus[1:0] ignored)
//  Data_out   in   32      CPU write data
//  Data_in    out  32      read data to CPU, registered
//  MIO_ready  out  1       one-cycle completion pulse
//  ram_addr   out  RAM_AW  = addr_bus[RAM_AW+1:2], registered at accept
//  ram_din    out  32      RAM write data
//  ram_we     out  1       RAM write enable, one cycle
//  ram_dout   in   32      RAM read data, valid RAM_LAT cycles after ram_addr
//  sw_in      in   16      switch inputs
//  led_out    out  16      LED register
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, MIO_ready=0, Data_in=0, ram_we=0, ram_addr=0, ram_din=0, led_out=0,
//    counter=0, wait counter=0. Reset mid-transaction abandons it; no ready is issued for it.
//  - Address map (addr_bus[31:28]): 0x0 RAM; 0xE LED reg (W; R returns {16'b0,led_out}); 0xF with
//    addr_bus[2]=0 switches (R {16'b0,sw_in}; W ignored), addr_bus[2]=1 counter (R/W). Others unmapped:
//    read returns 0, write ignored, still completes.
//  - Request = CPU_MIO & (MemRead|MemWrite). MemRead&MemWrite both set: treated as write, Data_in <= 0.
//  - FSM states IDLE, RAM_WAIT, DONE:
//    IDLE: on request, latch address, decode, Data_out, direction. RAM read -> RAM_WAIT (wait cnt=RAM_LAT);
//      any write or IO read -> DONE. RAM write: ram_we=1 for the accept cycle only.
//    RAM_WAIT: decrement wait cnt; at cnt==1 capture ram_dout into Data_in, -> DONE.
//    DONE: MIO_ready=1 exactly this cycle; -> IDLE. IO reads capture Data_in on the accept cycle.
//  - Latency (accept cycle = 0): write/IO read ready at cycle 1; RAM read ready at cycle 1+RAM_LAT.
//  - Data_in holds last read value until next read completes; writes leave Data_in unchanged (except both-set case).
//  - Request still high in IDLE after DONE is a new back-to-back transaction (CPU drops request after ready).
//  - Request inputs are ignored outside IDLE; changes mid-transaction have no effect.
//  - Counter: +1 every cycle, wraps 2^CNT_W-1 -> 0. CPU write in same cycle as increment: write wins,
//    counter = Data_out[CNT_W-1:0] next cycle, increments thereafter. Read returns value at accept cycle.
//  - LED write: led_out <= Data_out[15:0] on accept cycle edge.
// TESTING
//  1 Reset: drive reset=0 mid RAM read -> all outputs 0, no MIO_ready; release, idle 5 cycles -> MIO_ready stays 0.
//  2 RAM: write 0xDEADBEEF @0x0000_0010, then read @0x10 with RAM_LAT=1 and 3 -> Data_in=0xDEADBEEF,
//    ready at cycle 2 / 4; ram_we one cycle, ram_addr=4.
//  3 IO: write 0x0001_A5A5 @0xE000_0000 -> led_out=0xA5A5, ready cycle 1; sw_in=0x1234, read @0xF000_0000 ->
//    Data_in=0x0000_1234.
//  4 Counter: write 0xFFFF_FFFE @0xF000_0004, read 2 cycles after ready -> value wrapped past 0; write at
//    increment edge -> written value wins.
//  5 Edge: read @0x8000_0000 -> Data_in=0, ready cycle 1; MemRead&MemWrite @0xE000_0000 -> LED written, Data_in=0.
//  6 Back-to-back: hold request through DONE -> second transaction accepted next IDLE, exactly two ready pulses.

Source files
------------

// File: rtl/mio_bus_resp.sv
// MIO bus responder: RAM / LED / switch / cycle-counter decode, one-cycle MIO_ready pulse per request.
// Latency: writes and IO reads ready 1 cycle after accept, RAM reads 1+RAM_LAT; requests ignored until IDLE.
module mio_bus_resp #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic             req, accept, is_wr;
  logic             sel_ram, sel_led, sel_sw, sel_cnt;
  logic [2:0]       wait_cnt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      io_rdata;
  logic             unused_bits;

  assign req     = CPU_MIO & (MemRead | MemWrite);
  assign accept  = (state == IDLE) & req;
  assign is_wr   = MemWrite;
  assign sel_ram = (addr_bus[31:28] == 4'h0);
  assign sel_led = (addr_bus[31:28] == 4'hE);
  assign sel_sw  = (addr_bus[31:28] == 4'hF) & ~addr_bus[2];
  assign sel_cnt = (addr_bus[31:28] == 4'hF) &  addr_bus[2];

  assign MIO_ready   = (state == DONE);
  assign unused_bits = ^{addr_bus, Data_out};

  always_comb begin
    io_rdata = '0;
    if (sel_led)      io_rdata = {16'h0000, led_out};
    else if (sel_sw)  io_rdata = {16'h0000, sw_in};
    else if (sel_cnt) io_rdata = 32'(cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req) state_nxt = (sel_ram && !is_wr) ? RAM_WAIT : DONE;
      RAM_WAIT: if (wait_cnt == 3'd1) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A counter write on the accept edge overrides that cycle's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Data_in  <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      led_out  <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
    end else begin
      ram_we <= 1'b0;
      cnt    <= cnt + CNT_W'(1);
      if (accept) begin
        ram_addr <= addr_bus[RAM_AW+1:2];
        if (is_wr) begin
          if (MemRead) Data_in <= '0;
          if (sel_ram) begin
            ram_we  <= 1'b1;
            ram_din <= Data_out;
          end
          if (sel_led) led_out <= Data_out[15:0];
          if (sel_cnt) cnt     <= Data_out[CNT_W-1:0];
        end else if (sel_ram) begin
          wait_cnt <= 3'(RAM_LAT);
        end else begin
          Data_in <= io_rdata;
        end
      end
      if (state == RAM_WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) Data_in <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_resp.sv
// Bench for mio_bus_resp: two instances (RAM_LAT 1 and 3) share stimulus, each with its own RAM model
// and request qualifier so each can complete and drop its request independently.
module tb_mio_bus_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mio1, mio3, MemRead, MemWrite;
  logic [31:0] addr_bus, Data_out;
  logic [15:0] sw_in;
  logic [31:0] din1, din3, ram_din1, ram_din3, ram_dout1, ram_dout3;
  logic        rdy1, rdy3, we1, we3;
  logic [9:0]  ra1, ra3, a3_q1, a3_q2;
  logic [15:0] led1, led3;
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];

  int checks = 0;
  int errors = 0;
  int rdy_n1 = 0, rdy_n3 = 0, we_n1 = 0, we_n3 = 0;
  logic [9:0]  we_addr1;
  logic [31:0] we_dat1;

  mio_bus_resp #(.RAM_AW(10), .RAM_LAT(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .reset(reset), .CPU_MIO(mio1), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr_bus(addr_bus), .Data_out(Data_out), .Data_in(din1), .MIO_ready(rdy1),
    .ram_addr(ra1), .ram_din(ram_din1), .ram_we(we1), .ram_dout(ram_dout1),
    .sw_in(sw_in), .led_out(led1)
  );

  mio_bus_resp #(.RAM_AW(10), .RAM_LAT(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .reset(reset), .CPU_MIO(mio3), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr_bus(addr_bus), .Data_out(Data_out), .Data_in(din3), .MIO_ready(rdy3),
    .ram_addr(ra3), .ram_din(ram_din3), .ram_we(we3), .ram_dout(ram_dout3),
    .sw_in(sw_in), .led_out(led3)
  );

  // RAM models: data appears RAM_LAT cycles after the accept edge that registers ram_addr.
  assign ram_dout1 = mem1[ra1];
  assign ram_dout3 = mem3[a3_q2];

  always @(posedge clk) begin
    if (we1) mem1[ra1] <= ram_din1;
    if (we3) mem3[ra3] <= ram_din3;
    a3_q1 <= ra3;
    a3_q2 <= a3_q1;
    if (rdy1) rdy_n1 <= rdy_n1 + 1;
    if (rdy3) rdy_n3 <= rdy_n3 + 1;
    if (we1) begin
      we_n1    <= we_n1 + 1;
      we_addr1 <= ra1;
      we_dat1  <= ram_din1;
    end
    if (we3) we_n3 <= we_n3 + 1;
  end

  // Issues one request to both instances; lat = ready cycle relative to accept (-1 on timeout).
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] dat,
                        output int lat1, output int lat3);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; addr_bus = addr; Data_out = dat;
    mio1 = 1'b1; mio3 = 1'b1;
    lat1 = -1; lat3 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mio1 && rdy1) begin lat1 = k; mio1 = 1'b0; end
      if (mio3 && rdy3) begin lat3 = k; mio3 = 1'b0; end
      if (!mio1 && !mio3) break;
    end
    mio1 = 1'b0; mio3 = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; mio1 = 1'b0; mio3 = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    addr_bus = '0; Data_out = '0; sw_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy1, we1, din1, ra1, ram_din1, led1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got rdy=%b we=%b din=%h ra=%h rdin=%h led=%h expected all 0",
               rdy1, we1, din1, ra1, ram_din1, led1);
    end
    checks++;
    if ({rdy3, we3, din3, ra3, ram_din3, led3} !== '0) begin
      errors++;
      $display("FAIL reset_dut3: got rdy=%b we=%b din=%h ra=%h rdin=%h led=%h expected all 0",
               rdy3, we3, din3, ra3, ram_din3, led3);
    end
    reset = 1'b1;
  endtask

  task automatic test_ram;
    int l1, l3;
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, l1, l3);
    repeat (2) @(negedge clk);
    checks++; if (l1 !== 1) begin errors++; $display("FAIL ram_wr_lat1: got %0d expected 1", l1); end
    checks++; if (l3 !== 1) begin errors++; $display("FAIL ram_wr_lat3: got %0d expected 1", l3); end
    checks++; if (we_n1 !== 1) begin errors++; $display("FAIL ram_we_cycles1: got %0d expected 1", we_n1); end
    checks++; if (we_n3 !== 1) begin errors++; $display("FAIL ram_we_cycles3: got %0d expected 1", we_n3); end
    checks++; if (we_addr1 !== 10'd4) begin errors++; $display("FAIL ram_addr: got %0d expected 4", we_addr1); end
    checks++;
    if (we_dat1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_din: got %h expected deadbeef", we_dat1); end
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, l1, l3);
    checks++; if (l1 !== 2) begin errors++; $display("FAIL ram_rd_lat1: got %0d expected 2", l1); end
    checks++; if (l3 !== 4) begin errors++; $display("FAIL ram_rd_lat3: got %0d expected 4", l3); end
    checks++;
    if (din1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_data1: got %h expected deadbeef", din1); end
    checks++;
    if (din3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_data3: got %h expected deadbeef", din3); end
  endtask

  task automatic test_io;
    int l1, l3;
    do_txn(1'b0, 1'b1, 32'hE000_0000, 32'h0001_A5A5, l1, l3);
    checks++; if (l1 !== 1) begin errors++; $display("FAIL led_wr_lat: got %0d expected 1", l1); end
    checks++; if (led1 !== 16'hA5A5) begin errors++; $display("FAIL led_val1: got %h expected a5a5", led1); end
    checks++; if (led3 !== 16'hA5A5) begin errors++; $display("FAIL led_val3: got %h expected a5a5", led3); end
    checks++;
    if (din1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_keeps_din: got %h expected deadbeef", din1); end
    sw_in = 16'h1234;
    do_txn(1'b1, 1'b0, 32'hF000_0000, 32'h0, l1, l3);
    checks++; if (l1 !== 1) begin errors++; $display("FAIL sw_rd_lat1: got %0d expected 1", l1); end
    checks++; if (l3 !== 1) begin errors++; $display("FAIL sw_rd_lat3: got %0d expected 1", l3); end
    checks++; if (din1 !== 32'h0000_1234) begin errors++; $display("FAIL sw_rd1: got %h expected 00001234", din1); end
    checks++; if (din3 !== 32'h0000_1234) begin errors++; $display("FAIL sw_rd3: got %h expected 00001234", din3); end
    do_txn(1'b1, 1'b0, 32'hE000_0000, 32'h0, l1, l3);
    checks++; if (din1 !== 32'h0000_A5A5) begin errors++; $display("FAIL led_rd: got %h expected 0000a5a5", din1); end
  endtask

  task automatic test_counter;
    int l1, l3;
    do_txn(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, l1, l3);
    @(negedge clk);
    do_txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, l1, l3);
    checks++; if (l1 !== 1) begin errors++; $display("FAIL cnt_rd_lat: got %0d expected 1", l1); end
    checks++; if (din1 !== 32'h0) begin errors++; $display("FAIL cnt_wrap1: got %h expected 00000000", din1); end
    checks++; if (din3 !== 32'h0) begin errors++; $display("FAIL cnt_wrap3: got %h expected 00000000", din3); end
    do_txn(1'b0, 1'b1, 32'hF000_0004, 32'h0000_0100, l1, l3);
    do_txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, l1, l3);
    checks++; if (din1 !== 32'h101) begin errors++; $display("FAIL cnt_wr_wins1: got %h expected 00000101", din1); end
    checks++; if (din3 !== 32'h101) begin errors++; $display("FAIL cnt_wr_wins3: got %h expected 00000101", din3); end
  endtask

  task automatic test_edge;
    int l1, l3;
    do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, l1, l3);
    checks++; if (l1 !== 1) begin errors++; $display("FAIL unmapped_lat: got %0d expected 1", l1); end
    checks++; if (din1 !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h expected 00000000", din1); end
    do_txn(1'b1, 1'b0, 32'hF000_0000, 32'h0, l1, l3);
    do_txn(1'b1, 1'b1, 32'hE000_0000, 32'h0000_5A5A, l1, l3);
    checks++; if (l1 !== 1) begin errors++; $display("FAIL both_lat: got %0d expected 1", l1); end
    checks++; if (led1 !== 16'h5A5A) begin errors++; $display("FAIL both_led: got %h expected 5a5a", led1); end
    checks++; if (din1 !== 32'h0) begin errors++; $display("FAIL both_din1: got %h expected 00000000", din1); end
    checks++; if (din3 !== 32'h0) begin errors++; $display("FAIL both_din3: got %h expected 00000000", din3); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pat1, pat3;
    sw_in = 16'hBEEF;
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; addr_bus = 32'hF000_0000; mio1 = 1'b1; mio3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat1[k] = rdy1;
      pat3[k] = rdy3;
      if (k == 2) begin mio1 = 1'b0; mio3 = 1'b0; MemRead = 1'b0; end
    end
    checks++; if (pat1 !== 4'b0101) begin errors++; $display("FAIL b2b_ready1: got %b expected 0101", pat1); end
    checks++; if (pat3 !== 4'b0101) begin errors++; $display("FAIL b2b_ready3: got %b expected 0101", pat3); end
    checks++; if (din1 !== 32'h0000_BEEF) begin errors++; $display("FAIL b2b_data: got %h expected 0000beef", din1); end
  endtask

  task automatic test_reset_mid;
    int l1, l3, s1, s3;
    @(negedge clk);
    MemRead = 1'b1; addr_bus = 32'h0000_0010; mio1 = 1'b1; mio3 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mio1 = 1'b0; mio3 = 1'b0; MemRead = 1'b0;
    #1;
    checks++;
    if ({rdy1, we1, din1, ra1, ram_din1, led1} !== '0) begin
      errors++;
      $display("FAIL mid_reset1: got rdy=%b din=%h ra=%h rdin=%h led=%h expected all 0",
               rdy1, din1, ra1, ram_din1, led1);
    end
    checks++;
    if ({rdy3, we3, din3, ra3, ram_din3, led3} !== '0) begin
      errors++;
      $display("FAIL mid_reset3: got rdy=%b din=%h ra=%h rdin=%h led=%h expected all 0",
               rdy3, din3, ra3, ram_din3, led3);
    end
    s1 = rdy_n1; s3 = rdy_n3;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rdy_n1 !== s1) begin errors++; $display("FAIL no_ready1: got %0d pulses expected 0", rdy_n1 - s1); end
    checks++; if (rdy_n3 !== s3) begin errors++; $display("FAIL no_ready3: got %0d pulses expected 0", rdy_n3 - s3); end
    do_txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, l1, l3);
    checks++; if (din1 !== 32'd6) begin errors++; $display("FAIL cnt_after_reset1: got %0d expected 6", din1); end
    checks++; if (din3 !== 32'd6) begin errors++; $display("FAIL cnt_after_reset3: got %0d expected 6", din3); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_io();
    test_counter();
    test_edge();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
